// File: rtl/mem_rdstream.sv
// mem_rdstream: burst read engine for a fixed-latency memory port.
// Issues sequential reads under a credit limit and streams the words
// out through a small FIFO as a valid/ready stream with a last marker.
//
// Ports:
//   rclk, rst_n        clock, async active-low reset
//   start, base, len   burst command (len=0 completes with no reads)
//   busy, done         burst in progress / one-cycle completion pulse
//   clrrdy             memory ready; no reads are issued while low
//   memre, memra       memory read enable and address
//   memdo              read data, valid G_LATENCY cycles after memre
//   dout_vld, dout_rdy stream handshake
//   dout, dout_last    stream data and final-word flag

module mem_rdstream #(
  parameter int G_RDADDR     = 10,
  parameter int G_RDWIDTH    = 16,
  parameter int G_LATENCY    = 3,
  parameter int G_FIFO_DEPTH = 4,
  parameter int G_CNTW       = G_RDADDR + 1
) (
  input  logic                 rclk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [G_RDADDR-1:0]  base,
  input  logic [G_CNTW-1:0]    len,
  output logic                 busy,
  output logic                 done,
  input  logic                 clrrdy,
  output logic                 memre,
  output logic [G_RDADDR-1:0]  memra,
  input  logic [G_RDWIDTH-1:0] memdo,
  output logic                 dout_vld,
  input  logic                 dout_rdy,
  output logic [G_RDWIDTH-1:0] dout,
  output logic                 dout_last
);

  localparam int PW = $clog2(G_FIFO_DEPTH);
  localparam int UW = $clog2(G_FIFO_DEPTH + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAITCLR = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  logic [1:0] state;
  logic       st_idle;
  logic       st_wait;
  logic       st_run;
  logic       st_drain;

  logic [G_RDADDR-1:0] addr_q;
  logic [G_CNTW-1:0]   left_q;
  logic [UW-1:0]       used_q;

  logic [G_LATENCY-1:0] pv_q;
  logic [G_LATENCY-1:0] pl_q;

  logic [G_RDWIDTH-1:0]    fd_q [G_FIFO_DEPTH];
  logic [G_FIFO_DEPTH-1:0] fl_q;
  logic [PW-1:0]           wp_q;
  logic [PW-1:0]           rp_q;
  logic [UW-1:0]           cnt_q;

  logic pop;
  logic push;
  logic push_last;
  logic credit_ok;
  logic issue;
  logic last_iss;
  logic fin;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    if (p == PW'(G_FIFO_DEPTH - 1))
      return '0;
    return p + PW'(1);
  endfunction

  assign st_idle  = (state == S_IDLE);
  assign st_wait  = (state == S_WAITCLR);
  assign st_run   = (state == S_RUN);
  assign st_drain = (state == S_DRAIN);

  assign dout_vld  = (cnt_q != '0);
  assign dout      = fd_q[rp_q];
  assign dout_last = dout_vld & fl_q[rp_q];
  assign pop       = dout_vld & dout_rdy;

  // used_q counts reads in flight plus words held in the FIFO.
  // A pop in this cycle frees its slot for an issue in this cycle.
  assign credit_ok = (used_q < UW'(G_FIFO_DEPTH)) | pop;

  assign issue = st_run & clrrdy
               & (left_q != '0) & credit_ok;
  assign last_iss = issue & (left_q == G_CNTW'(1));

  assign memre = issue;
  assign memra = addr_q;

  assign push      = pv_q[G_LATENCY-1];
  assign push_last = pl_q[G_LATENCY-1];

  assign fin = st_drain & pop & dout_last;

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      addr_q <= '0;
      left_q <= '0;
    end else begin
      done <= 1'b0;
      unique case (1'b1)
        st_idle: begin
          if (start) begin
            if (len != '0) begin
              addr_q <= base;
              left_q <= len;
              busy   <= 1'b1;
              state  <= S_WAITCLR;
            end else begin
              done <= 1'b1;
            end
          end
        end
        st_wait: begin
          if (clrrdy)
            state <= S_RUN;
        end
        st_run: begin
          if (issue) begin
            addr_q <= addr_q + G_RDADDR'(1);
            left_q <= left_q - G_CNTW'(1);
            if (last_iss)
              state <= S_DRAIN;
          end
        end
        st_drain: begin
          if (fin) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Shift left so bit 0 is the newest read; the MSB lines up with
  // the cycle its data is on memdo.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q   <= '0;
      pl_q   <= '0;
      used_q <= '0;
    end else begin
      pv_q   <= (pv_q << 1) | G_LATENCY'(issue);
      pl_q   <= (pl_q << 1) | G_LATENCY'(last_iss);
      used_q <= used_q + UW'(issue) - UW'(pop);
    end
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < G_FIFO_DEPTH; i++)
        fd_q[i] <= '0;
      fl_q  <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        fd_q[wp_q] <= memdo;
        fl_q[wp_q] <= push_last;
        wp_q       <= nxt(wp_q);
      end
      if (pop)
        rp_q <= nxt(rp_q);
      cnt_q <= cnt_q + UW'(push) - UW'(pop);
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (
    @(posedge rclk) disable iff (!rst_n)
    !(push && !pop && cnt_q == UW'(G_FIFO_DEPTH))
  );
`endif

endmodule

// File: tb/tb_mem_rdstream.sv
// tb_mem_rdstream: table-driven and randomized bench for mem_rdstream.
// Fixed-latency memory model, queue scoreboard, credit/stall monitor.

module tb_mem_rdstream;

  localparam int AW  = 10;
  localparam int DW  = 16;
  localparam int LAT = 3;
  localparam int DEP = 4;
  localparam int CW  = 11;

  logic          rclk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base;
  logic [CW-1:0] len;
  logic          busy;
  logic          done;
  logic          clrrdy;
  logic          memre;
  logic [AW-1:0] memra;
  logic [DW-1:0] memdo;
  logic          dout_vld;
  logic          dout_rdy;
  logic [DW-1:0] dout;
  logic          dout_last;

  int checks = 0;
  int errors = 0;

  always #5 rclk = ~rclk;

  mem_rdstream #(
    .G_RDADDR(AW),
    .G_RDWIDTH(DW),
    .G_LATENCY(LAT),
    .G_FIFO_DEPTH(DEP),
    .G_CNTW(CW)
  ) dut (
    .rclk(rclk),
    .rst_n(rst_n),
    .start(start),
    .base(base),
    .len(len),
    .busy(busy),
    .done(done),
    .clrrdy(clrrdy),
    .memre(memre),
    .memra(memra),
    .memdo(memdo),
    .dout_vld(dout_vld),
    .dout_rdy(dout_rdy),
    .dout(dout),
    .dout_last(dout_last)
  );

  // memory: data for a read issued in cycle t is on memdo in t+LAT
  logic [DW-1:0] mem [1 << AW];
  logic [AW-1:0] pa  [LAT];
  logic          pv  [LAT];

  always @(posedge rclk) begin
    pv[0] <= memre;
    pa[0] <= memra;
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end

  assign memdo = (pv[LAT-1] === 1'b1) ? mem[pa[LAT-1]] : 16'hDEAD;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } word_t;

  typedef struct {
    logic [AW-1:0] base;
    int len;
    int rdy;
    int clo;
    int chi;
    int rst_at;
    int e_me;
    int e_vl;
    int e_lme;
    int e_dn;
  } row_t;

  word_t         exp_q [$];
  logic [AW-1:0] addr_q [$];
  int  outst    = 0;
  int  done_cnt = 0;
  bit  running  = 1'b0;
  logic          p_vld  = 1'b0;
  logic          p_rdy  = 1'b0;
  logic          p_last = 1'b0;
  logic          p_done = 1'b0;
  logic [DW-1:0] p_dout = '0;

  task automatic chk(input bit ok, input string nm,
                     input int act, input int exp_v);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  always @(negedge rclk) begin : mon
    bit pop;
    bit need;
    word_t w;
    logic [AW-1:0] a;
    pop = dout_vld && dout_rdy;
    if (rst_n) begin
      if (p_vld && !p_rdy)
        chk(dout_vld && dout == p_dout && dout_last == p_last,
            "stall_hold", int'({dout_vld, dout_last, dout}),
            int'({1'b1, p_last, p_dout}));
      if (pop) begin
        if (exp_q.size() == 0)
          chk(1'b0, "extra_word", int'(dout), -1);
        else begin
          w = exp_q.pop_front();
          chk(dout == w.d && dout_last == w.l, "dout",
              int'({dout_last, dout}), int'({w.l, w.d}));
        end
      end
      need = busy && running && addr_q.size() > 0 && clrrdy
          && (outst - int'(pop)) < DEP;
      if (need)
        chk(memre, "memre_credit", int'(memre), 1);
      if (memre) begin
        chk(clrrdy, "memre_clr_low", int'(clrrdy), 1);
        if (addr_q.size() == 0)
          chk(1'b0, "extra_memre", int'(memra), -1);
        else begin
          a = addr_q.pop_front();
          chk(memra == a, "memra", int'(memra), int'(a));
        end
        running = 1'b1;
      end
      outst = outst + int'(memre) - int'(pop);
      chk(outst <= DEP, "outstanding", outst, DEP);
      if (done) begin
        chk(!busy && !p_done, "done_pulse",
            int'({busy, p_done}), 0);
        done_cnt++;
      end
    end
    p_vld  = dout_vld;
    p_rdy  = dout_rdy;
    p_dout = dout;
    p_last = dout_last;
    p_done = done;
  end

  task automatic do_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    clrrdy   = 1'b1;
    dout_rdy = 1'b1;
    repeat (2) @(posedge rclk);
    #1;
    exp_q.delete();
    addr_q.delete();
    outst   = 0;
    running = 1'b0;
    rst_n   = 1'b1;
  endtask

  task automatic drive(input row_t r, input int k);
    clrrdy = !(k >= r.clo && k < r.chi);
    case (r.rdy)
      0:       dout_rdy = 1'b1;
      1:       dout_rdy = ((k >> 1) & 1) == 0;
      default: dout_rdy = $urandom_range(0, 3) != 0;
    endcase
  endtask

  task automatic run_burst(input row_t r,
                           output int t_me, output int t_vl,
                           output int t_lme, output int t_dn);
    int k;
    int bound;
    int d0;
    logic [AW-1:0] a;
    t_me  = -1;
    t_vl  = -1;
    t_lme = -1;
    t_dn  = -1;
    bound = r.len * 4 + 200;
    for (int i = 0; i < r.len; i++) begin
      a = r.base + AW'(i);
      addr_q.push_back(a);
      exp_q.push_back('{mem[a], (i == r.len - 1)});
    end
    running = 1'b0;
    d0 = done_cnt;
    k = 0;
    start = 1'b1;
    base  = r.base;
    len   = CW'(r.len);
    drive(r, 0);
    while (k < bound) begin
      @(negedge rclk);
      if (k == 0)
        chk(!busy, "busy_idle", int'(busy), 0);
      if (k == 1)
        chk(busy == (r.len != 0), "busy_rise",
            int'(busy), int'(r.len != 0));
      if (memre) begin
        if (t_me < 0) t_me = k;
        t_lme = k;
      end
      if (dout_vld && t_vl < 0) t_vl = k;
      if (done) begin
        t_dn = k;
        break;
      end
      @(posedge rclk);
      #1;
      k++;
      start = (k == r.rst_at);
      base  = r.base ^ 10'h155;
      len   = CW'(5);
      drive(r, k);
    end
    if (t_dn < 0) begin
      chk(1'b0, "done_timeout", k, bound);
      do_reset();
    end else begin
      @(posedge rclk);
      #1;
      start    = 1'b0;
      clrrdy   = 1'b1;
      dout_rdy = 1'b1;
      chk(exp_q.size() == 0 && addr_q.size() == 0, "drained",
          exp_q.size() + addr_q.size(), 0);
      chk(done_cnt == d0 + 1, "done_count", done_cnt - d0, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    row_t tbl [9];
    row_t r;
    int t_me, t_vl, t_lme, t_dn;
    int seen;
    int d0;

    // rows: base len rdy clo chi rst_at | memre vld last_memre done
    // -1 = never happens, -2 = not compared
    tbl[0] = '{10'h010,    5, 0, 0,  0, -1,  2,  6,    6,   11};
    tbl[1] = '{10'h3FE,    4, 0, 0,  0, -1,  2,  6,    5,   10};
    tbl[2] = '{10'h155,    1, 0, 0,  0, -1,  2,  6,    2,    7};
    tbl[3] = '{10'h0AA,    0, 0, 0,  0, -1, -1, -1,   -1,    1};
    tbl[4] = '{10'h080,    6, 0, 0,  0,  4,  2,  6,    7,   12};
    tbl[5] = '{10'h200,    3, 0, 0, 10, -1, 11, 15,   13,   18};
    tbl[6] = '{10'h0C0,    8, 0, 4,  7, -1,  2,  6,   12,   17};
    tbl[7] = '{10'h040,   16, 1, 0,  0, -1,  2,  6,   -2,   -2};
    tbl[8] = '{10'h2A5, 1024, 0, 0,  0, -1,  2,  6, 1025, 1030};

    for (int i = 0; i < (1 << AW); i++)
      mem[i] = DW'(i);
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pa[i] = '0;
    end

    rst_n    = 1'b0;
    start    = 1'b0;
    base     = '0;
    len      = '0;
    clrrdy   = 1'b1;
    dout_rdy = 1'b1;
    repeat (3) @(posedge rclk);
    #1;
    chk({busy, done, memre, memra, dout_vld, dout, dout_last} == '0,
        "reset_outputs",
        int'({busy, done, memre, memra, dout_vld, dout, dout_last}), 0);
    rst_n = 1'b1;
    @(posedge rclk);
    #1;

    for (int i = 0; i < 9; i++) begin
      r = tbl[i];
      run_burst(r, t_me, t_vl, t_lme, t_dn);
      if (r.e_me != -2)
        chk(t_me == r.e_me, $sformatf("row%0d first_memre", i),
            t_me, r.e_me);
      if (r.e_vl != -2)
        chk(t_vl == r.e_vl, $sformatf("row%0d first_vld", i),
            t_vl, r.e_vl);
      if (r.e_lme != -2)
        chk(t_lme == r.e_lme, $sformatf("row%0d last_memre", i),
            t_lme, r.e_lme);
      if (r.e_dn != -2)
        chk(t_dn == r.e_dn, $sformatf("row%0d done", i),
            t_dn, r.e_dn);
    end

    // reset with two reads in flight
    for (int i = 0; i < 8; i++) begin
      addr_q.push_back(10'h300 + AW'(i));
      exp_q.push_back('{mem[10'h300 + i], (i == 7)});
    end
    running = 1'b0;
    start = 1'b1;
    base  = 10'h300;
    len   = CW'(8);
    @(posedge rclk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge rclk);
    #1;
    chk(addr_q.size() == 6, "inflight_before_reset",
        8 - addr_q.size(), 2);
    rst_n = 1'b0;
    #1;
    chk({busy, done, memre, memra, dout_vld, dout, dout_last} == '0,
        "reset_midburst_outputs",
        int'({busy, done, memre, memra, dout_vld, dout, dout_last}), 0);
    exp_q.delete();
    addr_q.delete();
    outst   = 0;
    running = 1'b0;
    d0 = done_cnt;
    repeat (2) @(posedge rclk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge rclk);
      seen += int'(memre) + int'(dout_vld) + int'(done) + int'(busy);
    end
    chk(seen == 0 && done_cnt == d0, "quiet_after_reset", seen, 0);
    @(posedge rclk);
    #1;
    r = '{10'h3FF, 2, 0, 0, 0, -1, -2, -2, -2, -2};
    run_burst(r, t_me, t_vl, t_lme, t_dn);
    chk(t_vl == 6, "post_reset_first_vld", t_vl, 6);

    // randomized bursts against the queue model
    for (int i = 0; i < (1 << AW); i++)
      mem[i] = DW'($urandom);
    for (int n = 0; n < 25; n++) begin
      r.base   = AW'($urandom_range(0, (1 << AW) - 1));
      r.len    = $urandom_range(1, 40);
      r.rdy    = 2;
      r.clo    = $urandom_range(0, 20);
      r.chi    = r.clo + $urandom_range(0, 5);
      r.rst_at = $urandom_range(1, 30);
      run_burst(r, t_me, t_vl, t_lme, t_dn);
      chk(t_me >= 2, "rand_first_memre", t_me, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_rdstream.md
# mem_rdstream

Read-side stream engine for the 1-read/1-write memory wrappers. It takes a burst command (base address, length) and issues sequential reads to a memory whose read data returns a fixed `G_LATENCY` cycles after `memre`. It buffers the returned words in a small credit-controlled FIFO and presents them as a valid/ready stream with a last-word marker. It sits between a memory wrapper's read port and any consumer that can apply backpressure, such as a packet transmitter or a DMA egress.

## Interface
- `G_RDADDR`, 10, read address width; addresses wrap modulo 2**G_RDADDR.
- `G_RDWIDTH`, 16, read data width.
- `G_LATENCY`, 3, cycles from `memre` to valid `memdo`; legal range 1..8.
- `G_FIFO_DEPTH`, 4, output buffer entries. Must be ≥ G_LATENCY+1 for full throughput; legal minimum 2.
- `G_CNTW`, G_RDADDR+1, width of the length field.

Ports:
- `rclk`  in  1  single clock for the whole block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle burst command strobe.
- `base`  in  G_RDADDR  first read address, sampled when `start` is accepted.
- `len`  in  G_CNTW  number of words to read (0..2**G_RDADDR), sampled with `start`.
- `busy`  out  1  high from command acceptance until the burst completes.
- `done`  out  1  one-cycle pulse at burst completion.
- `clrrdy`  in  1  memory clear-complete status; reads are never issued while it is low.
- `memre`  out  1  memory read enable.
- `memra`  out  G_RDADDR  memory read address.
- `memdo`  in  G_RDWIDTH  memory read data, valid G_LATENCY cycles after `memre`.
- `dout_vld`  out  1  stream data valid.
- `dout_rdy`  in  1  consumer ready.
- `dout`  out  G_RDWIDTH  stream data.
- `dout_last`  out  1  marks the final word of the burst; qualified by `dout_vld`.

## Operation
- FSM states: IDLE, WAITCLR, RUN, DRAIN.
- IDLE:
  - `start`=1 with `len`≠0: latch `base`/`len`, `busy`←1, go to WAITCLR.
  - `start`=1 with `len`=0: `done` pulses on the next cycle, `busy` stays 0, no reads are issued.
- WAITCLR: move to RUN on the first cycle `clrrdy`=1; stay otherwise.
- RUN:
  - Issue one read per cycle while all of these hold: `clrrdy`=1, words remain to issue, and in-flight + FIFO occupancy < G_FIFO_DEPTH (credit rule).
  - `memra` starts at `base` and increments by 1 per issued read, wrapping from 2**G_RDADDR−1 to 0.
  - If `clrrdy` drops during RUN, issuing pauses; words already in flight are still captured.
  - After the last read is issued, go to DRAIN.
- DRAIN:
  - Wait until the last-flagged word completes its handshake (`dout_vld`&`dout_rdy`&`dout_last`).
  - Then: `done`←1 for one cycle, `busy`←0, return to IDLE.
- In-flight tracking:
  - A G_LATENCY-deep shift register carries `memre` and the last-word flag.
  - When its tail bit is 1, `memdo` and the flag are written into the FIFO.
  - Because of the credit rule, the FIFO never overflows. Overflow is an assertion failure.
- `start` while `busy`=1 is ignored; no state change.
- Words leave the FIFO in issue order. `dout`/`dout_last` hold stable while `dout_vld`=1 and `dout_rdy`=0.
- Reset:
  - Every output resets to 0, the FSM to IDLE, and all FIFO and pipeline contents are discarded.
  - A reset in the middle of a burst aborts it with no `done` pulse.
  - Memory data that returns after reset deasserts is ignored, because the pipeline flags were cleared.

## Timing
- `busy` rises the cycle after `start` is accepted.
- First `memre` is, at the earliest, the cycle after entering RUN. This gives 2 cycles from `start` when `clrrdy`=1.
- Read latency: `memre` at cycle t, `memdo` captured at the t+G_LATENCY edge, `dout_vld` asserted at t+G_LATENCY+1.
- Start-to-first-data: G_LATENCY+3 cycles when `clrrdy`=1 and the FIFO is empty.
- Throughput is 1 word/cycle with `dout_rdy` held high and G_FIFO_DEPTH ≥ G_LATENCY+1. Smaller depths throttle `memre` to the available credits.
- `done` is asserted the cycle after the last handshake. `busy` falls in the same cycle `done` is high.
- A new `start` is accepted in the cycle `done` is high (the FSM is already in IDLE).
- A read credit is returned in the same cycle the FIFO pops, so a pop and an issue in the same cycle are allowed.

## Test plan
- **Basic burst.** `base`=0x010, `len`=5, `dout_rdy`=1, `clrrdy`=1, and the memory model returns data = address.
  - `memra` = 0x010..0x014 on consecutive cycles.
  - `dout` = 0x010..0x014, back to back, with `dout_last` on 0x014.
  - First `dout_vld` 6 cycles after `start`; one `done` pulse.
- **Wrap.** `base`=0x3FE, `len`=4.
  - `memra` = 0x3FE, 0x3FF, 0x000, 0x001, and `dout` follows the same order.
- **Backpressure.** `len`=16 with `dout_rdy` toggling 1/0 every 2 cycles.
  - No word is lost or duplicated, and `dout` is stable while stalled.
  - In-flight + FIFO occupancy never exceeds 4, and `memre` stalls accordingly.
- **Clear gating.** `clrrdy`=0 when `start` arrives (`len`=3), and `clrrdy` rises 10 cycles later.
  - No `memre` before the rise; first `memre` in the cycle after.
  - In a second run, `clrrdy` drops for 3 cycles mid-burst and issuing pauses exactly for those cycles.
- **Edge commands.**
  - `len`=0: `done` pulses the next cycle, with no `memre` and no `dout_vld`.
  - `start` pulsed again mid-burst: ignored, and the first burst completes unaffected.
  - `len`=1024: all addresses read once.
- **Reset mid-burst.** Assert `rst_n`=0 while 2 reads are in flight.
  - All outputs are 0 immediately, and no `done` pulse follows.
  - A following burst with `len`=2 produces exactly 2 correct words.
